// File: rtl/noc_pkg.sv
// Shared NoC arbitration types and constants.
// Holds the arbiter state encoding, credit counter width, the maximum
// requester count, and a wrapping index increment used by the round-robin
// pointer.
package noc_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} noc_arb_state_t;

    localparam int unsigned NOC_CREDIT_W = 4;
    localparam int unsigned NOC_MAX_REQ  = 8;
    localparam int unsigned NOC_IDX_W    = 3;

    // Next requester index after idx, wrapping at num_req.
    function automatic logic [NOC_IDX_W-1:0] noc_next_idx(
        input logic [NOC_IDX_W-1:0] idx,
        input int unsigned          num_req
    );
        return (idx == NOC_IDX_W'(num_req - 1)) ? '0 : idx + NOC_IDX_W'(1);
    endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Bundle of the arbiter's requester-side, link-side and credit/status
// signals.
//   master : the environment (packetizers, downstream router, credit return)
//   slave  : the arbiter
// Requester i occupies slice i of every packed per-requester vector.
interface noc_output_arbiter_if
    import noc_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);

    logic [NUM_REQ-1:0]            in_flit_valid;
    logic [NUM_REQ-1:0]            in_flit_ready;
    logic [NUM_REQ*FLIT_WIDTH-1:0] in_flit_data;
    logic [NUM_REQ*ADDR_WIDTH-1:0] in_src_addr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] in_dst_addr;
    logic [NUM_REQ-1:0]            in_head_flit;
    logic [NUM_REQ-1:0]            in_tail_flit;

    logic                          out_flit_valid;
    logic                          out_flit_ready;
    logic [FLIT_WIDTH-1:0]         out_flit_data;
    logic [ADDR_WIDTH-1:0]         out_src_addr;
    logic [ADDR_WIDTH-1:0]         out_dst_addr;
    logic                          out_head_flit;
    logic                          out_tail_flit;

    logic                          credit_valid;
    logic [NOC_CREDIT_W-1:0]       credit_count;
    logic [NOC_CREDIT_W-1:0]       credits_avail;
    logic                          busy;
    logic [NOC_IDX_W-1:0]          grant_idx;
    logic                          credit_overflow;

    modport master (
        output in_flit_valid, in_flit_data, in_src_addr, in_dst_addr,
               in_head_flit, in_tail_flit,
        input  in_flit_ready,
        input  out_flit_valid, out_flit_data, out_src_addr, out_dst_addr,
               out_head_flit, out_tail_flit,
        output out_flit_ready,
        output credit_valid, credit_count,
        input  credits_avail, busy, grant_idx, credit_overflow
    );

    modport slave (
        input  in_flit_valid, in_flit_data, in_src_addr, in_dst_addr,
               in_head_flit, in_tail_flit,
        output in_flit_ready,
        output out_flit_valid, out_flit_data, out_src_addr, out_dst_addr,
               out_head_flit, out_tail_flit,
        input  out_flit_ready,
        input  credit_valid, credit_count,
        output credits_avail, busy, grant_idx, credit_overflow
    );

endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot winner
//   idx       : binary winner index (0 when nothing requests)
//   any_grant : at least one request present
// The pointer lives in the parent so it only advances on packet completion.
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NOC_IDX_W-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NOC_IDX_W-1:0] idx,
    output logic                 any_grant
);

    // First pass scans ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_grant && req[i] && (NOC_IDX_W'(i) >= ptr)) begin
                grant[i]  = 1'b1;
                idx       = NOC_IDX_W'(i);
                any_grant = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_grant && req[i] && (NOC_IDX_W'(i) < ptr)) begin
                grant[i]  = 1'b1;
                idx       = NOC_IDX_W'(i);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output arbiter: shares one NoC link among NUM_REQ requesters with
// packet-level round-robin arbitration and credit-based flow control.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester flits in, muxed link flit out, credit return in,
//              credits_avail / busy / grant_idx / credit_overflow status out
// The link datapath is a zero-latency combinational mux of the selected
// requester; only state, pointer, grant index and credits are registered.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_output_arbiter_if.slave  bus
);

    localparam int unsigned CSUM_W = NOC_CREDIT_W + 1;

    noc_arb_state_t          state_q, state_d;
    logic [NOC_IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NOC_IDX_W-1:0]    grant_idx_q, grant_idx_d;
    logic [NOC_CREDIT_W-1:0] credits_q, credits_d;
    logic                    overflow_q, overflow_d;

    logic [NUM_REQ-1:0]      arb_grant;
    logic [NOC_IDX_W-1:0]    arb_idx;
    logic                    arb_any;

    logic [NOC_IDX_W-1:0]    sel_idx;
    logic                    sel_valid;
    logic                    sel_head;
    logic                    sel_tail;
    logic [FLIT_WIDTH-1:0]   sel_data;
    logic [ADDR_WIDTH-1:0]   sel_src;
    logic [ADDR_WIDTH-1:0]   sel_dst;

    logic                    credit_ok;
    logic                    ready_en;
    logic                    xfer;
    logic [CSUM_W-1:0]       credit_sum;

    // Only head flits compete for a new packet slot.
    noc_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (bus.in_flit_valid & bus.in_head_flit),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .idx       (arb_idx),
        .any_grant (arb_any)
    );

    // Selected requester: locked owner, else this cycle's arbitration winner.
    always_comb begin
        sel_idx   = (state_q == ARB_LOCKED) ? grant_idx_q : arb_idx;
        sel_valid = 1'b0;
        sel_head  = 1'b0;
        sel_tail  = 1'b0;
        sel_data  = '0;
        sel_src   = '0;
        sel_dst   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (NOC_IDX_W'(i) == sel_idx) begin
                sel_valid = bus.in_flit_valid[i];
                sel_head  = bus.in_head_flit[i];
                sel_tail  = bus.in_tail_flit[i];
                sel_data  = bus.in_flit_data[i*FLIT_WIDTH +: FLIT_WIDTH];
                sel_src   = bus.in_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_dst   = bus.in_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        // In IDLE a non-head valid never counts as a request.
        if (state_q == ARB_IDLE) begin
            sel_valid = arb_any;
        end
    end

    // Link outputs and per-requester ready, gated by credits and reset.
    always_comb begin
        credit_ok          = (credits_q != '0);
        ready_en           = !rst && bus.out_flit_ready && credit_ok;
        bus.out_flit_valid = !rst && sel_valid && credit_ok;
        bus.out_flit_data  = sel_data;
        bus.out_src_addr   = sel_src;
        bus.out_dst_addr   = sel_dst;
        bus.out_head_flit  = sel_head;
        bus.out_tail_flit  = sel_tail;
        bus.in_flit_ready  = '0;
        if (state_q == ARB_IDLE) begin
            bus.in_flit_ready = arb_grant & {NUM_REQ{ready_en}};
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.in_flit_ready[i] = (NOC_IDX_W'(i) == grant_idx_q) && ready_en;
            end
        end
        xfer = bus.out_flit_valid && bus.out_flit_ready;
    end

    // Next-state: packet lock, round-robin pointer, credits.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        credits_d   = credits_q;
        overflow_d  = overflow_q;

        case (state_q)
            ARB_IDLE: begin
                if (xfer) begin
                    grant_idx_d = arb_idx;
                    if (sel_tail) begin
                        rr_ptr_d = noc_next_idx(arb_idx, NUM_REQ);
                    end else begin
                        state_d = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                if (xfer && sel_tail) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = noc_next_idx(grant_idx_q, NUM_REQ);
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Send and return in the same cycle both apply; excess saturates.
        credit_sum = {1'b0, credits_q} - CSUM_W'(xfer)
                   + (bus.credit_valid ? {1'b0, bus.credit_count} : CSUM_W'(0));
        if (credit_sum > CSUM_W'(BUF_DEPTH)) begin
            credits_d  = NOC_CREDIT_W'(BUF_DEPTH);
            overflow_d = 1'b1;
        end else begin
            credits_d  = credit_sum[NOC_CREDIT_W-1:0];
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            credits_q   <= NOC_CREDIT_W'(BUF_DEPTH);
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            credits_q   <= credits_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.busy            = (state_q == ARB_LOCKED);
    assign bus.grant_idx       = grant_idx_q;
    assign bus.credits_avail   = credits_q;
    assign bus.credit_overflow = overflow_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: directed vector table, a reset-mid-packet
// sequence, and randomized traffic against a packet-level reference model.
module tb_noc_output_arbiter;
    import noc_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned FW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned BD = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_output_arbiter_if #(.NUM_REQ(NR), .FLIT_WIDTH(FW), .ADDR_WIDTH(AW)) bus ();

    noc_output_arbiter #(
        .NUM_REQ    (NR),
        .FLIT_WIDTH (FW),
        .ADDR_WIDTH (AW),
        .BUF_DEPTH  (BD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0] v, h, t;
        logic       ordy, cv;
        logic [3:0] cc;
        logic [3:0] e_rdy;
        logic       e_ov;
        int         e_sel;
        logic       e_busy;
        logic [3:0] e_cred;
        logic       e_ovf;
        logic [2:0] e_gidx;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [FW-1:0] drv_data [NR];
    logic [AW-1:0] drv_src  [NR];
    logic [AW-1:0] drv_dst  [NR];

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [3:0] v, h, t, input logic ordy, cv, input logic [3:0] cc,
        input logic [3:0] e_rdy, input logic e_ov, input int e_sel,
        input logic e_busy, input logic [3:0] e_cred, input logic e_ovf,
        input logic [2:0] e_gidx);
        vec_t x;
        x.v = v; x.h = h; x.t = t; x.ordy = ordy; x.cv = cv; x.cc = cc;
        x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_sel = e_sel; x.e_busy = e_busy;
        x.e_cred = e_cred; x.e_ovf = e_ovf; x.e_gidx = e_gidx;
        return x;
    endfunction

    task automatic drive(input logic [3:0] v, h, t, input logic ordy, cv, input logic [3:0] cc);
        bus.in_flit_valid  = v;
        bus.in_head_flit   = h;
        bus.in_tail_flit   = t;
        bus.out_flit_ready = ordy;
        bus.credit_valid   = cv;
        bus.credit_count   = cc;
        for (int i = 0; i < NR; i++) begin
            bus.in_flit_data[i*FW +: FW] = drv_data[i];
            bus.in_src_addr[i*AW +: AW]  = drv_src[i];
            bus.in_dst_addr[i*AW +: AW]  = drv_dst[i];
        end
    endtask

    task automatic check_vec(input vec_t x, input string tag);
        check({tag, ".ready"},   32'(bus.in_flit_ready),   32'(x.e_rdy));
        check({tag, ".ovalid"},  32'(bus.out_flit_valid),  32'(x.e_ov));
        check({tag, ".busy"},    32'(bus.busy),            32'(x.e_busy));
        check({tag, ".credits"}, 32'(bus.credits_avail),   32'(x.e_cred));
        check({tag, ".ovf"},     32'(bus.credit_overflow), 32'(x.e_ovf));
        check({tag, ".gidx"},    32'(bus.grant_idx),       32'(x.e_gidx));
        if (x.e_ov) begin
            check({tag, ".data"}, 32'(bus.out_flit_data), 32'(drv_data[x.e_sel]));
            check({tag, ".src"},  32'(bus.out_src_addr),  32'(drv_src[x.e_sel]));
            check({tag, ".dst"},  32'(bus.out_dst_addr),  32'(drv_dst[x.e_sel]));
            check({tag, ".head"}, 32'(bus.out_head_flit), 32'(x.h[x.e_sel]));
            check({tag, ".tail"}, 32'(bus.out_tail_flit), 32'(x.t[x.e_sel]));
        end
    endtask

    // Apply one vector: drive after the edge, check mid-cycle, then clock it in.
    task automatic run_vec(input vec_t x, input string tag);
        drive(x.v, x.h, x.t, x.ordy, x.cv, x.cc);
        @(negedge clk);
        check_vec(x, tag);
        @(posedge clk);
        #1;
    endtask

    // Reference model state (packet-level view).
    bit m_locked;
    int m_owner, m_ptr, m_cred, m_gidx;
    bit m_ovf;

    task automatic model_reset();
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cred = BD; m_gidx = 0; m_ovf = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        vec_t x;
        logic [3:0] v, h, t, cc, e_rdy;
        logic ordy, cv, e_ov;
        int g, c;

        for (int i = 0; i < NR; i++) begin
            drv_data[i] = 32'hD0D0_0000 + 32'(i);
            drv_src[i]  = 8'h10 + 8'(i);
            drv_dst[i]  = 8'h20 + 8'(i);
        end
        pulse_reset();

        // 3-flit packet from req0 while others offer heads
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 0,  4'h0, 0, 0, 0, 8, 0, 0));
        vecs.push_back(mk(4'hF, 4'hF, 4'h0, 1, 0, 0,  4'h1, 1, 0, 0, 8, 0, 0));
        vecs.push_back(mk(4'hF, 4'hE, 4'h0, 1, 0, 0,  4'h1, 1, 0, 1, 7, 0, 0));
        vecs.push_back(mk(4'hF, 4'hE, 4'h1, 1, 0, 0,  4'h1, 1, 0, 1, 6, 0, 0));
        // req1 vs req2: req1 wins, then req2 wins over req1's new head
        vecs.push_back(mk(4'h6, 4'h6, 4'h0, 1, 0, 0,  4'h2, 1, 1, 0, 5, 0, 0));
        vecs.push_back(mk(4'h6, 4'h4, 4'h2, 1, 0, 0,  4'h2, 1, 1, 1, 4, 0, 1));
        vecs.push_back(mk(4'h6, 4'h6, 4'h6, 1, 0, 0,  4'h4, 1, 2, 0, 3, 0, 1));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 6,  4'h0, 0, 0, 0, 2, 0, 2));
        // 10-flit packet from req0 with credit exhaustion
        vecs.push_back(mk(4'h1, 4'h1, 4'h0, 1, 0, 0,  4'h1, 1, 0, 0, 8, 0, 2));
        for (int k = 7; k >= 1; k--)
            vecs.push_back(mk(4'h1, 4'h0, 4'h0, 1, 0, 0, 4'h1, 1, 0, 1, 4'(k), 0, 0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 1, 0, 0,  4'h0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 1, 1, 2,  4'h0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 1, 0, 0,  4'h1, 1, 0, 1, 2, 0, 0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h1, 1, 0, 0,  4'h1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 5,  4'h0, 0, 0, 0, 0, 0, 0));
        // send + return 3 at 5 credits, then overflow by returning 5 at 6
        vecs.push_back(mk(4'h1, 4'h1, 4'h1, 1, 1, 3,  4'h1, 1, 0, 0, 5, 0, 0));
        vecs.push_back(mk(4'h1, 4'h1, 4'h1, 1, 0, 0,  4'h1, 1, 0, 0, 7, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 5,  4'h0, 0, 0, 0, 6, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 0,  4'h0, 0, 0, 0, 8, 1, 0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 0,  4'h0, 0, 0, 0, 8, 1, 0));
        // single-flit packets from every requester, rotating grants
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 1,  4'h2, 1, 1, 0, 8, 1, 0));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 1,  4'h4, 1, 2, 0, 8, 1, 1));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 1,  4'h8, 1, 3, 0, 8, 1, 2));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 1,  4'h1, 1, 0, 0, 8, 1, 3));
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 1,  4'h2, 1, 1, 0, 8, 1, 0));
        // link not ready: no transfer, winner re-arbitrated next cycle
        vecs.push_back(mk(4'hF, 4'hF, 4'hF, 0, 0, 0,  4'h0, 1, 2, 0, 8, 1, 1));
        vecs.push_back(mk(4'hA, 4'hA, 4'h0, 0, 0, 0,  4'h0, 1, 3, 0, 8, 1, 1));
        // body flit without head in IDLE is never granted
        vecs.push_back(mk(4'h4, 4'h0, 4'h0, 1, 0, 0,  4'h0, 0, 0, 0, 8, 1, 1));

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while locked mid-packet, then req3 is granted normally.
        run_vec(mk(4'h1, 4'h1, 4'h0, 1, 0, 0, 4'h1, 1, 0, 0, 8, 1, 1), "rst.head");
        run_vec(mk(4'h1, 4'h0, 4'h0, 1, 0, 0, 4'h1, 1, 0, 1, 7, 1, 0), "rst.body");
        rst = 1'b1;
        drive(4'h1, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        check("rst.during.ready",  32'(bus.in_flit_ready),  32'h0);
        check("rst.during.ovalid", 32'(bus.out_flit_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec(mk(4'h0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 0, 8, 0, 0), "rst.after");
        run_vec(mk(4'h9, 4'h8, 4'h8, 1, 0, 0, 4'h8, 1, 3, 0, 8, 0, 0), "rst.req3");
        run_vec(mk(4'h0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 0, 7, 0, 3), "rst.done");

        // Randomized traffic against the reference model.
        pulse_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 1000 == 999) pulse_reset();
            v    = 4'($urandom);
            h    = 4'($urandom);
            t    = 4'($urandom) & 4'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            cv   = ($urandom_range(0, 3) == 0);
            cc   = 4'($urandom_range(0, 3));
            for (int i = 0; i < NR; i++) begin
                drv_data[i] = $urandom;
                drv_src[i]  = 8'($urandom);
                drv_dst[i]  = 8'($urandom);
            end

            g = -1;
            if (m_locked) begin
                g = m_owner;
            end else begin
                for (int k = 0; k < NR; k++) begin
                    int i;
                    i = (m_ptr + k) % NR;
                    if (g < 0 && v[i] && h[i]) g = i;
                end
            end
            e_ov  = 1'b0;
            e_rdy = 4'h0;
            if (g >= 0) begin
                e_ov = v[g] && (m_cred > 0);
                if (ordy && m_cred > 0) e_rdy = 4'(1 << g);
            end

            x = mk(v, h, t, ordy, cv, cc, e_rdy, e_ov, (g < 0) ? 0 : g,
                   m_locked, 4'(m_cred), m_ovf, 3'(m_gidx));
            run_vec(x, $sformatf("rnd%0d", cyc));

            if (e_ov && ordy) begin
                if (!m_locked) begin
                    m_gidx = g;
                    if (t[g]) m_ptr = (g + 1) % NR;
                    else begin
                        m_locked = 1'b1;
                        m_owner  = g;
                    end
                end else if (t[g]) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % NR;
                end
            end
            c = m_cred - ((e_ov && ordy) ? 1 : 0) + (cv ? int'(cc) : 0);
            if (c > int'(BD)) begin
                c     = BD;
                m_ovf = 1'b1;
            end
            m_cred = c;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Shares one NoC sender link among NUM_REQ local requesters: packet-level (wormhole) round-robin arbitration plus credit-based flow control toward the downstream receiver buffer.
- A grant is taken on a head flit and held until the matching tail flit transfers.
- Flit-level gating by available downstream credits.
- Sits between core/DMA packetizers and a router input port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- FLIT_WIDTH, 32, flit payload width
- ADDR_WIDTH, 8, node address width
- BUF_DEPTH, 8, downstream buffer depth in flits; initial and maximum credit count (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_flit_valid  in  NUM_REQ  per-requester flit valid
- in_flit_ready  out  NUM_REQ  per-requester flit accepted
- in_flit_data  in  NUM_REQ*FLIT_WIDTH  packed flits, requester i at [i*FLIT_WIDTH +: FLIT_WIDTH]
- in_src_addr  in  NUM_REQ*ADDR_WIDTH  packed source addresses
- in_dst_addr  in  NUM_REQ*ADDR_WIDTH  packed destination addresses
- in_head_flit  in  NUM_REQ  head marker
- in_tail_flit  in  NUM_REQ  tail marker
- out_flit_valid  out  1  link flit valid
- out_flit_ready  in  1  link ready
- out_flit_data  out  FLIT_WIDTH  muxed flit
- out_src_addr  out  ADDR_WIDTH  muxed source address
- out_dst_addr  out  ADDR_WIDTH  muxed destination address
- out_head_flit  out  1  muxed head marker
- out_tail_flit  out  1  muxed tail marker
- credit_valid  in  1  credit return strobe
- credit_count  in  4  credits returned when credit_valid=1
- credits_avail  out  4  current credit counter
- busy  out  1  packet lock held
- grant_idx  out  3  current or last-granted requester
- credit_overflow  out  1  sticky error flag

Behaviour:
- One clock domain, clk. Reset rst is synchronous, active-high.
- Reset values:
  - state = IDLE
  - credits_avail = BUF_DEPTH
  - rr_ptr = 0, grant_idx = 0
  - busy = 0, credit_overflow = 0
  - out_flit_valid = 0, all in_flit_ready = 0
- Transfer: a flit transfers in a cycle where out_flit_valid && out_flit_ready. For the granted requester g, in_flit_ready[g] = out_flit_ready && credits_avail != 0. All other in_flit_ready bits are 0.
- Datapath: out_* is a combinational mux of requester g's inputs. out_flit_valid = in_flit_valid[g] && credits_avail != 0. This gives zero-cycle forwarding latency.
- State IDLE:
  - Candidates are requesters i with in_flit_valid[i] && in_head_flit[i].
  - Pick the first candidate at or after rr_ptr, wrapping modulo NUM_REQ. That winner is g for this cycle.
  - No candidate: out_flit_valid = 0.
  - Valid flits without head in IDLE are never granted (ready held 0).
  - Head transfers with tail=0: go to LOCKED, latch grant_idx = g, busy = 1.
  - Head transfers with tail=1 (single-flit packet): stay IDLE, rr_ptr = g+1 mod NUM_REQ.
  - Head not transferred (no credit or not ready): no state change. The next cycle re-arbitrates, and a higher-priority head may win.
- State LOCKED:
  - g = latched grant_idx. Other requesters are ignored.
  - Head flits from g while LOCKED are forwarded unchanged (no protocol check).
  - Tail transfer: go to IDLE, busy = 0, rr_ptr = grant_idx+1 mod NUM_REQ.
- Credits (4-bit counter):
  - next = credits_avail - xfer + (credit_valid ? credit_count : 0).
  - Simultaneous send and return are both applied in the same cycle.
  - If next > BUF_DEPTH: saturate to BUF_DEPTH and set credit_overflow (sticky until rst).
  - credit_count = 0 with credit_valid = 1 is a no-op.
  - At credits_avail = 0, valid is gated off and the lock is held.
- Reset mid-packet: the lock is dropped and credits return to BUF_DEPTH. The partial packet is abandoned; upstream/downstream recovery is the system's responsibility.

Decomposition:
- Shared package noc_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} noc_arb_state_t
  - NOC_CREDIT_W = 4
  - NOC_MAX_REQ = 8
- One sub-module: noc_rr_arbiter.
  - Combinational round-robin picker.
  - Inputs: req vector, ptr. Outputs: onehot grant, binary index, any_grant.
  - The pointer register stays in the parent so it advances only on packet completion.

Test Plan:
- Reset, then req0 sends a 3-flit packet (H, B, T) with out_flit_ready=1 and no credit return -> 3 transfers on consecutive cycles, credits_avail 8→5, busy high after the head until the tail cycle, in_flit_ready[1..3]=0 throughout.
- req1 and req2 both present heads in IDLE, rr_ptr=0 -> req1 wins. After req1's tail, rr_ptr=2 and req2 is granted next even though req1 presents a new head.
- Credit exhaustion: BUF_DEPTH=8, req0 streams a 10-flit packet with no credit return -> 8 flits transfer, then out_flit_valid=0 with busy held. credit_valid=1, credit_count=2 -> the remaining 2 flits transfer and credits end at 0.
- Simultaneous transfer and return of credit_count=3 at credits_avail=5 -> credits_avail=7 next cycle. Return of 5 at credits_avail=6 with no transfer -> saturates at 8, credit_overflow=1, stays 1 until rst.
- Single-flit packets (head=tail=1) from all 4 requesters every cycle -> grants 0,1,2,3,0 in order, busy never asserts.
- rst asserted while LOCKED mid-packet -> next cycle state IDLE, busy=0, credits_avail=8, all in_flit_ready=0. A head from req3 is then granted normally.
